// File: rtl/gate_ops_pkg.sv
// rtl/gate_ops_pkg.sv - opcode and FSM state types shared by the gate arbiter and its logic unit
package gate_ops_pkg;

  typedef enum logic [2:0] {
    OP_AND  = 3'd0,
    OP_OR   = 3'd1,
    OP_NOT  = 3'd2,
    OP_NAND = 3'd3,
    OP_NOR  = 3'd4,
    OP_XOR  = 3'd5,
    OP_XNOR = 3'd6,
    OP_RSVD = 3'd7
  } gate_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_e;

endpackage

// File: rtl/logic_op_unit.sv
// rtl/logic_op_unit.sv - bitwise logic unit whose every gate function is built from NAND primitives
import gate_ops_pkg::*;

module logic_op_unit #(
  parameter int W = 8
) (
  input  gate_op_e       op,
  input  logic [W-1:0]   a,
  input  logic [W-1:0]   b,
  output logic [W-1:0]   y
);

  logic [W-1:0] na, nb, nand_ab, and_ab, or_ab, nor_ab;
  logic [W-1:0] xa, xb, xor_ab, xnor_ab;

  for (genvar i = 0; i < W; i++) begin : g_bit
    nand u_na   (na[i],      a[i],       a[i]);
    nand u_nb   (nb[i],      b[i],       b[i]);
    nand u_nab  (nand_ab[i], a[i],       b[i]);
    nand u_and  (and_ab[i],  nand_ab[i], nand_ab[i]);
    nand u_or   (or_ab[i],   na[i],      nb[i]);
    nand u_nor  (nor_ab[i],  or_ab[i],   or_ab[i]);
    // Classic four-NAND XOR sharing the a NAND b term
    nand u_xa   (xa[i],      a[i],       nand_ab[i]);
    nand u_xb   (xb[i],      b[i],       nand_ab[i]);
    nand u_xor  (xor_ab[i],  xa[i],      xb[i]);
    nand u_xnor (xnor_ab[i], xor_ab[i],  xor_ab[i]);
  end

  always_comb begin
    y = '0;
    case (op)
      OP_AND:  y = and_ab;
      OP_OR:   y = or_ab;
      OP_NOT:  y = na;
      OP_NAND: y = nand_ab;
      OP_NOR:  y = nor_ab;
      OP_XOR:  y = xor_ab;
      OP_XNOR: y = xnor_ab;
      default: y = '0;
    endcase
  end

endmodule

// File: rtl/gate_op_arbiter.sv
// rtl/gate_op_arbiter.sv - round-robin arbiter sharing one logic unit among N_REQ requesters
import gate_ops_pkg::*;

module gate_op_arbiter #(
  parameter int N_REQ = 4,
  parameter int W     = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_valid,
  output logic [N_REQ-1:0]         req_ready,
  input  logic [N_REQ*3-1:0]       req_op,
  input  logic [N_REQ*W-1:0]       req_a,
  input  logic [N_REQ*W-1:0]       req_b,
  output logic                     rsp_valid,
  input  logic                     rsp_ready,
  output logic [W-1:0]             rsp_data,
  output logic [$clog2(N_REQ)-1:0] rsp_id,
  output logic                     rsp_err,
  output logic                     busy,
  output logic [CNT_W-1:0]         op_count
);

  localparam int ID_W = $clog2(N_REQ);

  arb_state_e       state_q, state_d;
  logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
  gate_op_e         op_q, op_d;
  logic [W-1:0]     a_q, a_d, b_q, b_d;
  logic [ID_W-1:0]  id_q, id_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [W-1:0]     rsp_data_q, rsp_data_d;
  logic [ID_W-1:0]  rsp_id_q, rsp_id_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             found;
  logic [ID_W-1:0]  winner;
  logic             accept;
  logic [W-1:0]     unit_y;

  // First valid requester at or after rr_ptr, wrapping past N_REQ-1
  always_comb begin
    int idx;
    logic [ID_W-1:0] cand;
    found  = 1'b0;
    winner = '0;
    idx    = 0;
    cand   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      cand = ID_W'(idx);
      if (!found && req_valid[cand]) begin
        found  = 1'b1;
        winner = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && found && !rst) req_ready[winner] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);

  logic_op_unit #(.W(W)) u_unit (
    .op (op_q),
    .a  (a_q),
    .b  (b_q),
    .y  (unit_y)
  );

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_id_d    = rsp_id_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          op_d    = gate_op_e'(req_op[3*winner +: 3]);
          a_d     = req_a[W*winner +: W];
          b_d     = req_b[W*winner +: W];
          id_d    = winner;
          state_d = EXEC;
        end
      end
      EXEC: begin
        rsp_data_d  = unit_y;
        rsp_err_d   = (op_q == OP_RSVD);
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cnt_d       = cnt_q + 1'b1;
          rr_ptr_d    = (id_q == ID_W'(N_REQ - 1)) ? '0 : id_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      op_q        <= OP_AND;
      a_q         <= '0;
      b_q         <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_id_q    <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_id_q    <= rsp_id_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_err   = rsp_err_q;
  assign busy      = (state_q != IDLE);
  assign op_count  = cnt_q;

endmodule

// File: tb/tb_gate_op_arbiter.sv
// tb/tb_gate_op_arbiter.sv - self-checking bench for gate_op_arbiter with a response scoreboard
module tb_gate_op_arbiter;

  typedef struct {
    logic [2:0] op;
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] exp;
    logic       err;
  } vec_t;

  typedef struct {
    logic [1:0] id;
    logic [7:0] data;
    logic       err;
  } rsp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req_valid;
  logic [3:0]  req_ready;
  logic [11:0] req_op;
  logic [31:0] req_a;
  logic [31:0] req_b;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic [1:0]  rsp_id;
  logic        rsp_err;
  logic        busy;
  logic [3:0]  op_count;

  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  rsp_t sb[$];
  logic [3:0] exp_cnt = 4'd0;
  bit   cnt_pending = 1'b0;
  vec_t vecs [8];

  gate_op_arbiter #(.N_REQ(4), .W(8), .CNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_id    (rsp_id),
    .rsp_err   (rsp_err),
    .busy      (busy),
    .op_count  (op_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic report_fail(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=event required=no-event at cycle %0d", name, cyc);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst       = 1'b1;
    req_valid = '0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic set_slot(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b);
    req_op[3*id +: 3] = op;
    req_a[8*id +: 8]  = a;
    req_b[8*id +: 8]  = b;
  endtask

  // Raise one request, wait for its grant, log the expected response, then drop it after the handshake
  task automatic issue(input int id, input logic [2:0] op, input logic [7:0] a, input logic [7:0] b,
                       input logic [7:0] exp, input logic err);
    int   n = 0;
    rsp_t e;
    set_slot(id, op, a, b);
    req_valid[id] = 1'b1;
    #1;
    while (!req_ready[id] && n < 20) begin
      step();
      n++;
    end
    if (n >= 20) report_fail("grant_timeout");
    check("grant_onehot", {28'd0, req_ready}, 32'(1) << id);
    e.id   = 2'(id);
    e.data = exp;
    e.err  = err;
    sb.push_back(e);
    step();
    req_valid[id] = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      step();
      n++;
    end
    if (n >= 50) report_fail("drain_timeout");
  endtask

  initial begin : monitor
    rsp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        sb.delete();
        exp_cnt     = 4'd0;
        cnt_pending = 1'b0;
      end else begin
        if (cnt_pending) begin
          check("op_count_track", {28'd0, op_count}, {28'd0, exp_cnt});
          cnt_pending = 1'b0;
        end
        if (rsp_valid && rsp_ready) begin
          if (sb.size() == 0) begin
            report_fail("unexpected_rsp");
          end else begin
            e = sb.pop_front();
            check("rsp_data", {24'd0, rsp_data}, {24'd0, e.data});
            check("rsp_id",   {30'd0, rsp_id},   {30'd0, e.id});
            check("rsp_err",  {31'd0, rsp_err},  {31'd0, e.err});
            exp_cnt     = exp_cnt + 4'd1;
            cnt_pending = 1'b1;
          end
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    int gcyc [5];
    int n;
    rsp_t e;

    vecs[0] = '{3'd0, 8'hAA, 8'hCC, 8'h88, 1'b0};
    vecs[1] = '{3'd1, 8'hAA, 8'hCC, 8'hEE, 1'b0};
    vecs[2] = '{3'd2, 8'hAA, 8'hCC, 8'h55, 1'b0};
    vecs[3] = '{3'd3, 8'hAA, 8'hCC, 8'h77, 1'b0};
    vecs[4] = '{3'd4, 8'hAA, 8'hCC, 8'h11, 1'b0};
    vecs[5] = '{3'd5, 8'hAA, 8'hCC, 8'h66, 1'b0};
    vecs[6] = '{3'd6, 8'hAA, 8'hCC, 8'h99, 1'b0};
    vecs[7] = '{3'd7, 8'hAA, 8'hCC, 8'h00, 1'b1};

    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    do_reset();

    check("reset_req_ready", {28'd0, req_ready}, 32'd0);
    check("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("reset_rsp_data",  {24'd0, rsp_data},  32'd0);
    check("reset_rsp_id",    {30'd0, rsp_id},    32'd0);
    check("reset_rsp_err",   {31'd0, rsp_err},   32'd0);
    check("reset_busy",      {31'd0, busy},      32'd0);
    check("reset_op_count",  {28'd0, op_count},  32'd0);

    // Single AND request on requester 1 with latency check
    issue(1, 3'd0, 8'hF0, 8'h3C, 8'h30, 1'b0);
    check("t1_exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("t1_exec_busy",      {31'd0, busy},      32'd1);
    check("t1_exec_req_ready", {28'd0, req_ready}, 32'd0);
    step();
    check("t1_rsp_valid", {31'd0, rsp_valid}, 32'd1);
    check("t1_rsp_data",  {24'd0, rsp_data},  32'h30);
    check("t1_rsp_id",    {30'd0, rsp_id},    32'd1);
    wait_drain();
    step();
    check("t1_op_count", {28'd0, op_count}, 32'd1);

    // All four requesters valid from reset: rotation 0,1,2,3,0 at a 3-cycle cadence
    do_reset();
    for (int i = 0; i < 4; i++) set_slot(i, vecs[i].op, vecs[i].a, vecs[i].b);
    req_valid = 4'hF;
    #1;
    for (int g = 0; g < 5; g++) begin
      n = 0;
      while (req_ready == 4'd0 && n < 20) begin
        step();
        n++;
      end
      if (n >= 20) report_fail("rotation_timeout");
      gcyc[g] = cyc;
      check("rotation_grant", {28'd0, req_ready}, 32'(1) << (g % 4));
      if (g > 0) check("rotation_cadence", 32'(gcyc[g] - gcyc[g-1]), 32'd3);
      e.id   = 2'(g % 4);
      e.data = vecs[g % 4].exp;
      e.err  = 1'b0;
      sb.push_back(e);
      step();
    end
    req_valid = '0;
    wait_drain();

    // Opcode sweep on requester 0
    for (int v = 0; v < 8; v++) begin
      issue(0, vecs[v].op, vecs[v].a, vecs[v].b, vecs[v].exp, vecs[v].err);
      wait_drain();
    end

    // Backpressure for 5 cycles; operands of the op in flight are overwritten meanwhile
    rsp_ready = 1'b0;
    issue(2, 3'd5, 8'h0F, 8'hFF, 8'hF0, 1'b0);
    set_slot(2, 3'd0, 8'h00, 8'h00);
    set_slot(3, 3'd1, 8'h12, 8'h34);
    req_valid[3] = 1'b1;
    step();
    for (int c = 0; c < 5; c++) begin
      check("bp_rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("bp_rsp_data",  {24'd0, rsp_data},  32'hF0);
      check("bp_rsp_id",    {30'd0, rsp_id},    32'd2);
      check("bp_req_ready", {28'd0, req_ready}, 32'd0);
      check("bp_op_count",  {28'd0, op_count},  {28'd0, exp_cnt});
      step();
    end
    req_valid[3] = 1'b0;
    rsp_ready    = 1'b1;
    wait_drain();

    // Reset while EXEC: op is lost and rr_ptr returns to 0 (was 3)
    issue(1, 3'd0, 8'hFF, 8'hFF, 8'hFF, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("rst_exec_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_exec_busy",      {31'd0, busy},      32'd0);
    check("rst_exec_op_count",  {28'd0, op_count},  32'd0);
    req_valid = 4'b1010;
    #1;
    check("rst_exec_rr_ptr", {28'd0, req_ready}, 32'b0010);
    req_valid = '0;
    for (int c = 0; c < 6; c++) begin
      step();
      check("rst_exec_no_rsp", {31'd0, rsp_valid}, 32'd0);
    end

    // Counter wrap with a 4-bit counter
    for (int k = 0; k < 16; k++) begin
      issue(k % 4, 3'd1, 8'(k), 8'h10, 8'(k) | 8'h10, 1'b0);
      wait_drain();
    end
    step();
    check("wrap_16", {28'd0, op_count}, 32'd0);
    issue(0, 3'd2, 8'h0F, 8'h00, 8'hF0, 1'b0);
    wait_drain();
    step();
    check("wrap_17", {28'd0, op_count}, 32'd1);

    step();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
